pong_game_ctrl: RTL
===================

# pong_game_ctrl

Game-flow controller for the Pong datapath. It sits directly downstream of the graphics/physics block and consumes that block's `hit[1:0]` and `miss` status. It drives that block's `gra_still` input and keeps the two players' scores for the text/score overlay. It sequences new-game, serve-delay, play and game-over phases, and emits one-cycle event pulses for the sound block.

## Interface
Parameters:
- `WIN_SCORE`, 9: points needed to win; valid range 1..15.
- `WAIT_CYCLES`, 200_000_000: length of the serve delay and the game-over hold, in `clk` cycles (2 s at 100 MHz); must be ≥1.

Ports:
- `clk`  in  1  system clock; the design has one clock.
- `reset`  in  1  asynchronous, active-high reset.
- `btn`  in  4  player buttons, already debounced and synchronous to `clk`; any bit starts a game.
- `hit`  in  2  paddle-contact level from the physics block; bit0 = left paddle, bit1 = right paddle; may stay high for many cycles.
- `miss`  in  1  ball-out level from the physics block; may stay high for many cycles.
- `gra_still`  out  1  freezes the ball at centre while high.
- `score_l`  out  4  left player score, binary.
- `score_r`  out  4  right player score, binary.
- `game_over`  out  1  high while in OVER.
- `winner`  out  1  0 = left, 1 = right; valid while `game_over` = 1.
- `hit_pulse`  out  1  one-cycle pulse per accepted paddle hit.
- `miss_pulse`  out  1  one-cycle pulse per accepted miss.

## Operation
- Edge detection uses registered copies `hit_d[1:0]`, `miss_d` and `btn_any_d` (= |btn delayed). A rising edge is `sig & ~sig_d`. These registers update every cycle in all states.
- `last_hitter` register: 0 = left, 1 = right.
  - Set to 1 on every entry to PLAY, because the serve travels left and an unreturned serve is the right player's point.
  - A left hit edge sets it to 0; a right hit edge sets it to 1.
  - If both hit edges occur in the same cycle, the right hit wins.
- Moore FSM with 4 states:
  - NEWGAME: `gra_still` = 1. A rising edge of |btn clears both scores, sets `last_hitter` = 1 and moves to PLAY.
  - PLAY: `gra_still` = 0.
    - Hit edges update `last_hitter` and fire `hit_pulse`.
    - A miss edge awards one point to the side given by `last_hitter` and fires `miss_pulse`. A hit edge in the same cycle is applied first.
    - If the awarded score equals `WIN_SCORE`, latch `winner` = `last_hitter` and go to OVER.
    - Otherwise load the timer with `WAIT_CYCLES`-1 and go to NEWBALL.
  - NEWBALL: `gra_still` = 1. The timer decrements each cycle. On the cycle it reads 0, set `last_hitter` = 1 and go to PLAY.
  - OVER: `gra_still` = 1, `game_over` = 1. Timer loaded on entry counts to 0, then go to NEWGAME. Scores and `winner` hold until the next game starts.
- Hit and miss edges outside PLAY are ignored: no pulses, no score change, no `last_hitter` change.
- Buttons are ignored outside NEWGAME.
- Scores saturate at 15 by construction (OVER is entered at `WIN_SCORE` ≤ 15).
- Timer width is `$clog2(WAIT_CYCLES)`, minimum 1 bit. With `WAIT_CYCLES` = 1, NEWBALL and OVER each last one cycle.

## Timing
- All outputs are registered or decoded directly from registers; there are no combinational input-to-output paths.
- Reset values: state NEWGAME, `gra_still` 1, `score_l`/`score_r` 0, `game_over` 0, `winner` 0, `hit_pulse`/`miss_pulse` 0, timer 0, `last_hitter` 1.
- Edge registers reset to `hit_d` = 0 and `miss_d` = 0. `btn_any_d` resets to 1, so a button held through reset does not start a game until it is released and pressed again.
- Latency: an input edge sampled at edge N updates state, scores and pulses at edge N+1. `gra_still` rises in the cycle after the miss edge is sampled.
- NEWBALL and OVER each last exactly `WAIT_CYCLES` cycles.
- A miss held high continuously produces only one point. A new point requires `miss` to fall and rise again while in PLAY.
- Reset asserted mid-game returns immediately (asynchronously) to the reset values; the timer is abandoned.

## Test plan
All scenarios use `WAIT_CYCLES` = 4 and `WIN_SCORE` = 2.
- Reset, then pulse `btn[2]` for 1 cycle -> PLAY one cycle later, `gra_still` 0, scores 0/0.
- In PLAY, raise `miss` and hold it 10 cycles with no prior hit -> `score_r` = 1, `miss_pulse` high exactly 1 cycle, `gra_still` high for 4 cycles, then 0.
- In PLAY, hold `hit[0]` 5 cycles, then raise `miss` -> exactly one `hit_pulse`, `score_l` increments by 1.
- Right player wins twice -> `game_over` = 1, `winner` = 1, `score_r` = 2 held for 4 cycles, then NEWGAME with the score held. A button edge clears the scores.
- Hold `btn[0]` through reset release -> stays in NEWGAME. Release then press -> PLAY.
- Assert `reset` during NEWBALL at timer = 2 -> all outputs return to reset values immediately. `hit`/`miss` edges in NEWGAME produce no pulses.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// Game-flow controller for the Pong datapath: sequences new-game, serve-delay,
// play and game-over phases, keeps both scores and emits sound event pulses.
module pong_game_ctrl #(
  parameter int WIN_SCORE   = 9,
  parameter int WAIT_CYCLES = 200_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  input  logic [1:0] hit,
  input  logic       miss,
  output logic       gra_still,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over,
  output logic       winner,
  output logic       hit_pulse,
  output logic       miss_pulse
);

  localparam int TW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [TW-1:0] TLOAD = TW'(WAIT_CYCLES - 1);
  localparam logic [TW-1:0] TONE  = TW'(1);
  localparam logic [3:0]    WIN   = 4'(WIN_SCORE);

  typedef enum logic [1:0] {S_NEWGAME, S_PLAY, S_NEWBALL, S_OVER} state_t;

  state_t        r_state, w_state_n;
  logic [1:0]    r_hit_d;
  logic          r_miss_d, r_btn_any_d;
  logic          r_last_hitter, w_last_n;
  logic [TW-1:0] r_timer, w_timer_n;
  logic [3:0]    r_score_l, r_score_r, w_score_l_n, w_score_r_n;
  logic          r_winner, w_winner_n;
  logic          r_hit_pulse, r_miss_pulse, w_hit_pulse_n, w_miss_pulse_n;

  logic [1:0]    w_hit_edge;
  logic          w_miss_edge, w_btn_edge;
  logic          w_lh_hit;
  logic [3:0]    w_point;

  assign w_hit_edge  = hit & ~r_hit_d;
  assign w_miss_edge = miss & ~r_miss_d;
  assign w_btn_edge  = (|btn) & ~r_btn_any_d;

  // Delayed copies of the inputs for rising-edge detection, updated in every state.
  // btn_any_d resets high so a button held through reset cannot start a game.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit_d     <= 2'b00;
      r_miss_d    <= 1'b0;
      r_btn_any_d <= 1'b1;
    end else begin
      r_hit_d     <= hit;
      r_miss_d    <= miss;
      r_btn_any_d <= |btn;
    end
  end

  // State, timer, scores, winner, last hitter and event pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_NEWGAME;
      r_last_hitter <= 1'b1;
      r_timer       <= '0;
      r_score_l     <= 4'd0;
      r_score_r     <= 4'd0;
      r_winner      <= 1'b0;
      r_hit_pulse   <= 1'b0;
      r_miss_pulse  <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_last_hitter <= w_last_n;
      r_timer       <= w_timer_n;
      r_score_l     <= w_score_l_n;
      r_score_r     <= w_score_r_n;
      r_winner      <= w_winner_n;
      r_hit_pulse   <= w_hit_pulse_n;
      r_miss_pulse  <= w_miss_pulse_n;
    end
  end

  // Next-state and next-register logic; hit edges are applied before a same-cycle miss.
  always_comb begin
    w_state_n      = r_state;
    w_last_n       = r_last_hitter;
    w_timer_n      = r_timer;
    w_score_l_n    = r_score_l;
    w_score_r_n    = r_score_r;
    w_winner_n     = r_winner;
    w_hit_pulse_n  = 1'b0;
    w_miss_pulse_n = 1'b0;
    w_lh_hit       = r_last_hitter;
    w_point        = 4'd0;
    case (r_state)
      S_NEWGAME: begin
        if (w_btn_edge) begin
          w_score_l_n = 4'd0;
          w_score_r_n = 4'd0;
          w_last_n    = 1'b1;
          w_state_n   = S_PLAY;
        end
      end
      S_PLAY: begin
        if (w_hit_edge[0]) w_lh_hit = 1'b0;
        if (w_hit_edge[1]) w_lh_hit = 1'b1;
        w_last_n      = w_lh_hit;
        w_hit_pulse_n = |w_hit_edge;
        if (w_miss_edge) begin
          w_miss_pulse_n = 1'b1;
          if (w_lh_hit) begin
            w_point     = r_score_r + 4'd1;
            w_score_r_n = w_point;
          end else begin
            w_point     = r_score_l + 4'd1;
            w_score_l_n = w_point;
          end
          w_timer_n = TLOAD;
          if (w_point == WIN) begin
            w_winner_n = w_lh_hit;
            w_state_n  = S_OVER;
          end else begin
            w_state_n  = S_NEWBALL;
          end
        end
      end
      S_NEWBALL: begin
        if (r_timer == '0) begin
          w_last_n  = 1'b1;
          w_state_n = S_PLAY;
        end else begin
          w_timer_n = r_timer - TONE;
        end
      end
      S_OVER: begin
        if (r_timer == '0) w_state_n = S_NEWGAME;
        else               w_timer_n = r_timer - TONE;
      end
      default: w_state_n = S_NEWGAME;
    endcase
  end

  assign gra_still  = (r_state != S_PLAY);
  assign game_over  = (r_state == S_OVER);
  assign score_l    = r_score_l;
  assign score_r    = r_score_r;
  assign winner     = r_winner;
  assign hit_pulse  = r_hit_pulse;
  assign miss_pulse = r_miss_pulse;

endmodule
